// File: rtl/cart_mapper.sv
// cart_mapper: bank-switching NES cart mapper core sitting between the
// synchronised cart bus and two SDRAM read channels (PRG for the CPU side,
// CHR for the PPU side).
//
// Ports:
//   clk_i, rst_i            SDRAM-domain clock, synchronous active-high reset
//   en_i                    low while loading: no fetches, CPU writes ignored
//   m2_i, cpu_rw_i,         raw CPU bus pins (asynchronous)
//   romsel_i, cpu_addr_i,
//   cpu_wdata_i
//   ppu_rd_i, ppu_addr_i    raw PPU bus pins (asynchronous)
//   prg_req_o/addr_o/ack_i/rdata_i, cpu_data_o   PRG SDRAM channel
//   chr_req_o/addr_o/ack_i/rdata_i, ppu_data_o   CHR SDRAM channel
//   ciram_a10_o             nametable mirroring select
//   irq_o                   active-low IRQ
//
// Build option: define CART_MAPPER_IRQ_EN to include the CPU-cycle IRQ
// counter; otherwise irq_o is tied high and the IRQ registers ignore writes.

// One SDRAM read channel: IDLE -> REQ (hold until ack) -> IDLE, with a
// single-entry pending slot where the newest trigger wins.
module cart_mapper_chan #(
  parameter int ADDR_W = 22
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              trig_i,
  input  logic [ADDR_W-1:0] taddr_i,
  input  logic              ack_i,
  input  logic [7:0]        rdata_i,
  output logic              req_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [7:0]        data_o
);
  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t              state_q;
  logic                req_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          data_q;
  logic                pend_vld_q;
  logic [ADDR_W-1:0]   pend_addr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A fresh trigger is newer than anything parked in the slot.
          if (trig_i) begin
            req_q      <= 1'b1;
            addr_q     <= taddr_i;
            pend_vld_q <= 1'b0;
            state_q    <= S_REQ;
          end else if (pend_vld_q) begin
            req_q      <= 1'b1;
            addr_q     <= pend_addr_q;
            pend_vld_q <= 1'b0;
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          // The slot stores the already-translated address, so later bank
          // writes do not retarget it.
          if (trig_i) begin
            pend_vld_q  <= 1'b1;
            pend_addr_q <= taddr_i;
          end
          if (ack_i) begin
            data_q  <= rdata_i;
            req_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_o  = req_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
endmodule

module cart_mapper #(
  parameter int              PRG_WIN    = 4,
  parameter int              PRG_BANK_W = 6,
  parameter int              CHR_WIN    = 8,
  parameter int              CHR_BANK_W = 8,
  parameter int              ADDR_W     = 22,
  parameter logic [ADDR_W-1:0] PRG_BASE = 22'h000000,
  parameter logic [ADDR_W-1:0] CHR_BASE = 22'h200000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              m2_i,
  input  logic              cpu_rw_i,
  input  logic              romsel_i,
  input  logic [14:0]       cpu_addr_i,
  input  logic [7:0]        cpu_wdata_i,
  input  logic              ppu_rd_i,
  input  logic [13:0]       ppu_addr_i,
  output logic              prg_req_o,
  output logic [ADDR_W-1:0] prg_addr_o,
  input  logic              prg_ack_i,
  input  logic [7:0]        prg_rdata_i,
  output logic [7:0]        cpu_data_o,
  output logic              chr_req_o,
  output logic [ADDR_W-1:0] chr_addr_o,
  input  logic              chr_ack_i,
  input  logic [7:0]        chr_rdata_i,
  output logic [7:0]        ppu_data_o,
  output logic              ciram_a10_o,
  output logic              irq_o
);
  localparam int PRG_OFF_W = 15 - $clog2(PRG_WIN);
  localparam int PRG_IDX_W = (PRG_WIN > 1) ? $clog2(PRG_WIN) : 1;
  localparam int CHR_OFF_W = 13 - $clog2(CHR_WIN);
  localparam int CHR_IDX_W = (CHR_WIN > 1) ? $clog2(CHR_WIN) : 1;

  // Synchronisers: [1] is the synchronised copy, [2] its previous value
  // (edge detection only needed on m2 and ppu_rd).
  logic [2:0] m2_q;
  logic [2:0] ppu_rd_q;
  logic [1:0] romsel_q;
  logic [1:0] rw_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m2_q     <= '0;
      ppu_rd_q <= '1;
      romsel_q <= '1;
      rw_q     <= '1;
    end else begin
      m2_q     <= {m2_q[1:0], m2_i};
      ppu_rd_q <= {ppu_rd_q[1:0], ppu_rd_i};
      romsel_q <= {romsel_q[0], romsel_i};
      rw_q     <= {rw_q[0], cpu_rw_i};
    end
  end

  logic m2_rise, m2_fall, ppu_fall;
  assign m2_rise  =  m2_q[1] & ~m2_q[2];
  assign m2_fall  = ~m2_q[1] &  m2_q[2];
  assign ppu_fall = ~ppu_rd_q[1] & ppu_rd_q[2];

  logic prg_trig, chr_trig, cpu_wr;
  assign prg_trig = m2_rise & ~romsel_q[1] & rw_q[1] & en_i;
  assign chr_trig = ppu_fall & ~ppu_addr_i[13] & en_i;
  assign cpu_wr   = m2_fall & ~romsel_q[1] & ~rw_q[1] & en_i;

  // Bank registers and mirroring mode.
  logic [PRG_BANK_W-1:0] prg_bank_q [PRG_WIN];
  logic [CHR_BANK_W-1:0] chr_bank_q [CHR_WIN];
  logic [1:0]            mirr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // Last PRG window points at the top bank so the reset vector is visible.
      for (int i = 0; i < PRG_WIN; i++)
        prg_bank_q[i] <= (i == PRG_WIN - 1) ? '1 : PRG_BANK_W'(i);
      for (int i = 0; i < CHR_WIN; i++)
        chr_bank_q[i] <= CHR_BANK_W'(i);
      mirr_q <= 2'd0;
    end else if (cpu_wr) begin
      if (!cpu_addr_i[4]) begin
        for (int i = 0; i < PRG_WIN; i++)
          if (cpu_addr_i[3:0] == 4'(i)) prg_bank_q[i] <= PRG_BANK_W'(cpu_wdata_i);
        for (int i = 0; i < CHR_WIN; i++)
          if (cpu_addr_i[3:0] == 4'(i + 8)) chr_bank_q[i] <= CHR_BANK_W'(cpu_wdata_i);
      end else if (cpu_addr_i[1:0] == 2'd0) begin
        mirr_q <= cpu_wdata_i[1:0];
      end
    end
  end

  // Address translation: window index from the top address bits, offset below.
  logic [PRG_IDX_W-1:0] prg_sel;
  logic [CHR_IDX_W-1:0] chr_sel;
  logic [ADDR_W-1:0]    prg_taddr, chr_taddr;

  assign prg_sel   = PRG_IDX_W'(cpu_addr_i >> PRG_OFF_W);
  assign chr_sel   = CHR_IDX_W'(ppu_addr_i[12:0] >> CHR_OFF_W);
  assign prg_taddr = PRG_BASE + ADDR_W'({prg_bank_q[prg_sel], cpu_addr_i[PRG_OFF_W-1:0]});
  assign chr_taddr = CHR_BASE + ADDR_W'({chr_bank_q[chr_sel], ppu_addr_i[CHR_OFF_W-1:0]});

  cart_mapper_chan #(.ADDR_W(ADDR_W)) u_prg (
    .clk_i(clk_i), .rst_i(rst_i), .trig_i(prg_trig), .taddr_i(prg_taddr),
    .ack_i(prg_ack_i), .rdata_i(prg_rdata_i),
    .req_o(prg_req_o), .addr_o(prg_addr_o), .data_o(cpu_data_o)
  );

  cart_mapper_chan #(.ADDR_W(ADDR_W)) u_chr (
    .clk_i(clk_i), .rst_i(rst_i), .trig_i(chr_trig), .taddr_i(chr_taddr),
    .ack_i(chr_ack_i), .rdata_i(chr_rdata_i),
    .req_o(chr_req_o), .addr_o(chr_addr_o), .data_o(ppu_data_o)
  );

  // Nametable mirroring, registered.
  logic ciram_d, ciram_q;
  always_comb begin
    ciram_d = 1'b0;
    case (mirr_q)
      2'd0: ciram_d = ppu_addr_i[10];
      2'd1: ciram_d = ppu_addr_i[11];
      2'd2: ciram_d = 1'b0;
      2'd3: ciram_d = 1'b1;
      default: ciram_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ciram_q <= 1'b0;
    else       ciram_q <= ciram_d;
  end
  assign ciram_a10_o = ciram_q;

`ifdef CART_MAPPER_IRQ_EN
  logic [15:0] irq_latch_q, irq_cnt_q;
  logic        irq_en_q, irq_q;
  logic        irq_wr;
  assign irq_wr = cpu_wr & cpu_addr_i[4];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_latch_q <= '0;
      irq_cnt_q   <= '0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b1;
    end else if (irq_wr && cpu_addr_i[1:0] == 2'd1) begin
      irq_latch_q[7:0] <= cpu_wdata_i;
    end else if (irq_wr && cpu_addr_i[1:0] == 2'd2) begin
      irq_latch_q[15:8] <= cpu_wdata_i;
    end else if (irq_wr && cpu_addr_i[1:0] == 2'd3) begin
      irq_q    <= 1'b1;
      irq_en_q <= cpu_wdata_i[0];
      if (cpu_wdata_i[0]) irq_cnt_q <= irq_latch_q;
    end else if (irq_en_q && m2_rise) begin
      // Reaching zero fires the IRQ and freezes the counter.
      if (irq_cnt_q <= 16'd1) begin
        irq_cnt_q <= '0;
        irq_q     <= 1'b0;
        irq_en_q  <= 1'b0;
      end else begin
        irq_cnt_q <= irq_cnt_q - 16'd1;
      end
    end
  end
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b1;
`endif
endmodule

// File: tb/tb_cart_mapper.sv
// Directed testbench for cart_mapper: reset state, PRG/CHR translation,
// bank writes, mirroring, pending-slot behaviour, reset abort, en gating, IRQ.
module tb_cart_mapper;
  logic        clk = 1'b0;
  logic        rst, en, m2, cpu_rw, romsel, ppu_rd;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [13:0] ppu_addr;
  logic        prg_req, prg_ack, chr_req, chr_ack, ciram_a10, irq;
  logic [21:0] prg_addr, chr_addr;
  logic [7:0]  prg_rdata, chr_rdata, cpu_data, ppu_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cart_mapper dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .m2_i(m2), .cpu_rw_i(cpu_rw),
    .romsel_i(romsel), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .ppu_rd_i(ppu_rd), .ppu_addr_i(ppu_addr),
    .prg_req_o(prg_req), .prg_addr_o(prg_addr), .prg_ack_i(prg_ack),
    .prg_rdata_i(prg_rdata), .cpu_data_o(cpu_data),
    .chr_req_o(chr_req), .chr_addr_o(chr_addr), .chr_ack_i(chr_ack),
    .chr_rdata_i(chr_rdata), .ppu_data_o(ppu_data),
    .ciram_a10_o(ciram_a10), .irq_o(irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [14:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_wdata = d; cpu_rw = 1'b0; romsel = 1'b0;
    tick();
    m2 = 1'b1;
    repeat (3) tick();
    m2 = 1'b0;
    repeat (3) tick();
    romsel = 1'b1; cpu_rw = 1'b1;
    tick();
  endtask

  // Full CPU read bus cycle without acknowledging the SDRAM side.
  task automatic cpu_bus_read(input logic [14:0] a);
    cpu_addr = a; cpu_rw = 1'b1; romsel = 1'b0;
    tick();
    m2 = 1'b1;
    repeat (4) tick();
    m2 = 1'b0;
    repeat (3) tick();
    romsel = 1'b1;
    tick();
  endtask

  task automatic m2_pulse();
    m2 = 1'b1;
    repeat (3) tick();
    m2 = 1'b0;
    repeat (3) tick();
  endtask

  // CPU read with ack; returns the requested address and whether req appeared.
  task automatic do_prg_read(input logic [14:0] a, input logic [7:0] rd,
                             output logic [21:0] got, output logic ok);
    ok = 1'b0; got = '0;
    cpu_addr = a; cpu_rw = 1'b1; romsel = 1'b0;
    tick();
    m2 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (prg_req) begin ok = 1'b1; break; end
      tick();
    end
    got = prg_addr;
    m2 = 1'b0;
    if (ok) begin
      prg_rdata = rd; prg_ack = 1'b1;
      tick();
      prg_ack = 1'b0;
    end
    repeat (3) tick();
    romsel = 1'b1;
    tick();
  endtask

  task automatic do_ppu_read(input logic [13:0] a, input logic [7:0] rd,
                             output logic [21:0] got, output logic ok);
    ok = 1'b0; got = '0;
    ppu_addr = a;
    tick();
    ppu_rd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (chr_req) begin ok = 1'b1; break; end
      tick();
    end
    got = chr_addr;
    if (ok) begin
      chr_rdata = rd; chr_ack = 1'b1;
      tick();
      chr_ack = 1'b0;
    end
    ppu_rd = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    total++; if (prg_req !== 1'b0) begin bad++; $display("FAIL rst_prg_req got=%0b exp=0", prg_req); end
    total++; if (prg_addr !== 22'h0) begin bad++; $display("FAIL rst_prg_addr got=%h exp=000000", prg_addr); end
    total++; if (cpu_data !== 8'h00) begin bad++; $display("FAIL rst_cpu_data got=%h exp=00", cpu_data); end
    total++; if (chr_req !== 1'b0 || chr_addr !== 22'h0 || ppu_data !== 8'h00) begin
      bad++; $display("FAIL rst_chr got req=%0b addr=%h data=%h exp 0/000000/00", chr_req, chr_addr, ppu_data); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL rst_irq got=%0b exp=1", irq); end
  endtask

  task automatic test_reset_vector();
    logic [21:0] a0;
    cpu_addr = 15'h7FFC; cpu_rw = 1'b1; romsel = 1'b0;
    tick();
    m2 = 1'b1;
    repeat (2) tick();
    total++; if (prg_req !== 1'b0) begin bad++; $display("FAIL latency_early got=%0b exp=0", prg_req); end
    tick();
    total++; if (prg_req !== 1'b1) begin bad++; $display("FAIL latency_3rd got=%0b exp=1", prg_req); end
    total++; if (prg_addr !== 22'h07FFFC) begin bad++; $display("FAIL rst_vector_addr got=%h exp=07fffc", prg_addr); end
    a0 = prg_addr;
    repeat (3) tick();
    total++; if (prg_req !== 1'b1 || prg_addr !== 22'h07FFFC || cpu_data !== 8'h00) begin
      bad++; $display("FAIL req_hold got req=%0b addr=%h data=%h exp 1/07fffc/00", prg_req, prg_addr, cpu_data); end
    prg_rdata = 8'hA5; prg_ack = 1'b1;
    tick();
    prg_ack = 1'b0;
    total++; if (cpu_data !== 8'hA5 || prg_req !== 1'b0) begin
      bad++; $display("FAIL ack_data got data=%h req=%0b exp a5/0", cpu_data, prg_req); end
    m2 = 1'b0;
    repeat (3) tick();
    romsel = 1'b1;
    tick();
  endtask

  task automatic test_prg_banks();
    logic [21:0] g; logic ok;
    cpu_write(15'h0002, 8'h05);
    do_prg_read(15'h4010, 8'h11, g, ok);
    total++; if (!ok || g !== 22'h00A010) begin bad++; $display("FAIL prg_bank2 got=%h ok=%0b exp=00a010", g, ok); end
    total++; if (cpu_data !== 8'h11) begin bad++; $display("FAIL prg_data got=%h exp=11", cpu_data); end
    cpu_write(15'h0001, 8'hC3);  // masked to 6 bits -> 03
    do_prg_read(15'h2000, 8'h22, g, ok);
    total++; if (!ok || g !== 22'h006000) begin bad++; $display("FAIL prg_mask got=%h ok=%0b exp=006000", g, ok); end
    cpu_write(15'h0005, 8'h3F);  // PRG index 5 beyond 4 windows: ignored
    do_prg_read(15'h6000, 8'h33, g, ok);
    total++; if (!ok || g !== 22'h07E000) begin bad++; $display("FAIL prg_ignored_w3 got=%h ok=%0b exp=07e000", g, ok); end
    cpu_write(15'h000F, 8'h02);  // CHR window 7
    do_prg_read(15'h4010, 8'h44, g, ok);
    total++; if (!ok || g !== 22'h00A010) begin bad++; $display("FAIL prg_unchanged got=%h ok=%0b exp=00a010", g, ok); end
  endtask

  task automatic test_chr();
    logic [21:0] g; logic ok;
    do_ppu_read(14'h0400, 8'h10, g, ok);
    total++; if (!ok || g !== 22'h200400) begin bad++; $display("FAIL chr_default got=%h ok=%0b exp=200400", g, ok); end
    cpu_write(15'h000B, 8'h21);
    do_ppu_read(14'h0C05, 8'h5A, g, ok);
    total++; if (!ok || g !== 22'h208405) begin bad++; $display("FAIL chr_bank3 got=%h ok=%0b exp=208405", g, ok); end
    total++; if (ppu_data !== 8'h5A) begin bad++; $display("FAIL ppu_data got=%h exp=5a", ppu_data); end
    do_ppu_read(14'h1C00, 8'h66, g, ok);
    total++; if (!ok || g !== 22'h200800) begin bad++; $display("FAIL chr_bank7 got=%h ok=%0b exp=200800", g, ok); end
    do_ppu_read(14'h2000, 8'h77, g, ok);
    total++; if (ok !== 1'b0) begin bad++; $display("FAIL chr_nametable_fetch got=%0b exp=0", ok); end
  endtask

  task automatic test_simultaneous();
    cpu_addr = 15'h4010; cpu_rw = 1'b1; romsel = 1'b0; ppu_addr = 14'h0C05;
    tick();
    m2 = 1'b1; ppu_rd = 1'b0;
    repeat (3) tick();
    total++; if (prg_req !== 1'b1 || chr_req !== 1'b1 || prg_addr !== 22'h00A010 || chr_addr !== 22'h208405) begin
      bad++; $display("FAIL simul_req got prg=%0b/%h chr=%0b/%h exp 1/00a010 1/208405", prg_req, prg_addr, chr_req, chr_addr); end
    chr_rdata = 8'hC3; chr_ack = 1'b1;
    tick();
    chr_ack = 1'b0;
    total++; if (ppu_data !== 8'hC3 || chr_req !== 1'b0 || prg_req !== 1'b1) begin
      bad++; $display("FAIL simul_chr_ack got data=%h chr_req=%0b prg_req=%0b exp c3/0/1", ppu_data, chr_req, prg_req); end
    prg_rdata = 8'h3C; prg_ack = 1'b1;
    tick();
    prg_ack = 1'b0;
    total++; if (cpu_data !== 8'h3C || prg_req !== 1'b0) begin
      bad++; $display("FAIL simul_prg_ack got data=%h req=%0b exp 3c/0", cpu_data, prg_req); end
    m2 = 1'b0; ppu_rd = 1'b1;
    repeat (3) tick();
    romsel = 1'b1;
    tick();
  endtask

  task automatic test_mirroring();
    cpu_write(15'h0010, 8'h01);
    ppu_addr = 14'h2800; repeat (2) tick();
    total++; if (ciram_a10 !== 1'b1) begin bad++; $display("FAIL mirr_h_2800 got=%0b exp=1", ciram_a10); end
    ppu_addr = 14'h2400; repeat (2) tick();
    total++; if (ciram_a10 !== 1'b0) begin bad++; $display("FAIL mirr_h_2400 got=%0b exp=0", ciram_a10); end
    cpu_write(15'h0010, 8'h03);
    ppu_addr = 14'h2800; repeat (2) tick();
    total++; if (ciram_a10 !== 1'b1) begin bad++; $display("FAIL mirr_1_2800 got=%0b exp=1", ciram_a10); end
    ppu_addr = 14'h2400; repeat (2) tick();
    total++; if (ciram_a10 !== 1'b1) begin bad++; $display("FAIL mirr_1_2400 got=%0b exp=1", ciram_a10); end
    cpu_write(15'h0010, 8'h00);
    repeat (2) tick();
    total++; if (ciram_a10 !== 1'b1) begin bad++; $display("FAIL mirr_v_2400 got=%0b exp=1", ciram_a10); end
    ppu_addr = 14'h2800; repeat (2) tick();
    total++; if (ciram_a10 !== 1'b0) begin bad++; $display("FAIL mirr_v_2800 got=%0b exp=0", ciram_a10); end
  endtask

  task automatic test_en();
    logic seen; logic [21:0] g; logic ok;
    seen = 1'b0;
    en = 1'b0;
    cpu_addr = 15'h0000; cpu_rw = 1'b1; romsel = 1'b0;
    tick();
    m2 = 1'b1;
    for (int i = 0; i < 8; i++) begin tick(); if (prg_req) seen = 1'b1; end
    m2 = 1'b0;
    repeat (3) tick();
    romsel = 1'b1;
    tick();
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL en_low_fetch got=%0b exp=0", seen); end
    cpu_write(15'h0002, 8'h11);
    en = 1'b1;
    do_prg_read(15'h4000, 8'h55, g, ok);
    total++; if (!ok || g !== 22'h00A000) begin bad++; $display("FAIL en_low_write got=%h ok=%0b exp=00a000", g, ok); end
  endtask

  task automatic test_pending();
    cpu_bus_read(15'h0000);
    total++; if (prg_req !== 1'b1 || prg_addr !== 22'h000000) begin
      bad++; $display("FAIL pend_first got req=%0b addr=%h exp 1/000000", prg_req, prg_addr); end
    cpu_bus_read(15'h0001);
    cpu_bus_read(15'h0002);
    total++; if (prg_req !== 1'b1 || prg_addr !== 22'h000000) begin
      bad++; $display("FAIL pend_hold got req=%0b addr=%h exp 1/000000", prg_req, prg_addr); end
    prg_rdata = 8'h01; prg_ack = 1'b1;
    tick();
    prg_ack = 1'b0;
    total++; if (prg_req !== 1'b0) begin bad++; $display("FAIL pend_drop got=%0b exp=0", prg_req); end
    tick();
    total++; if (prg_req !== 1'b1 || prg_addr !== 22'h000002) begin
      bad++; $display("FAIL pend_newest got req=%0b addr=%h exp 1/000002", prg_req, prg_addr); end
    prg_rdata = 8'h02; prg_ack = 1'b1;
    tick();
    prg_ack = 1'b0;
    repeat (8) tick();
    total++; if (prg_req !== 1'b0 || cpu_data !== 8'h02) begin
      bad++; $display("FAIL pend_single got req=%0b data=%h exp 0/02", prg_req, cpu_data); end
  endtask

  task automatic test_reset_mid();
    logic [21:0] g; logic ok;
    cpu_bus_read(15'h0003);
    total++; if (prg_req !== 1'b1) begin bad++; $display("FAIL abort_pre got=%0b exp=1", prg_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (prg_req !== 1'b0) begin bad++; $display("FAIL abort_req got=%0b exp=0", prg_req); end
    prg_rdata = 8'h77; prg_ack = 1'b1;
    tick();
    prg_ack = 1'b0;
    tick();
    total++; if (cpu_data !== 8'h00 || prg_req !== 1'b0) begin
      bad++; $display("FAIL late_ack got data=%h req=%0b exp 00/0", cpu_data, prg_req); end
    do_prg_read(15'h4000, 8'h88, g, ok);
    total++; if (!ok || g !== 22'h004000) begin bad++; $display("FAIL bank_reset got=%h ok=%0b exp=004000", g, ok); end
  endtask

  task automatic test_irq();
`ifdef CART_MAPPER_IRQ_EN
    cpu_write(15'h0011, 8'h10);
    cpu_write(15'h0012, 8'h00);
    cpu_write(15'h0013, 8'h01);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_armed got=%0b exp=1", irq); end
    repeat (15) m2_pulse();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_15 got=%0b exp=1", irq); end
    m2_pulse();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_16 got=%0b exp=0", irq); end
    m2_pulse();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_hold got=%0b exp=0", irq); end
    cpu_write(15'h0013, 8'h00);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_ack got=%0b exp=1", irq); end
`else
    cpu_write(15'h0011, 8'h01);
    cpu_write(15'h0012, 8'h00);
    cpu_write(15'h0013, 8'h01);
    repeat (4) m2_pulse();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_tied got=%0b exp=1", irq); end
`endif
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; m2 = 1'b0; cpu_rw = 1'b1; romsel = 1'b1; ppu_rd = 1'b1;
    cpu_addr = '0; cpu_wdata = '0; ppu_addr = '0;
    prg_ack = 1'b0; chr_ack = 1'b0; prg_rdata = '0; chr_rdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_reset_vector();
    test_prg_banks();
    test_chr();
    test_simultaneous();
    test_mirroring();
    test_en();
    test_pending();
    test_reset_mid();
    test_irq();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
